// File: rtl/muldiv_unit_pkg.sv
// Shared core package: ALU and multiply/divide opcode definitions plus
// decode helpers used by the M-extension unit.
package muldiv_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic [3:0] {
        MDU_MUL    = 4'd0,
        MDU_MULH   = 4'd1,
        MDU_MULHSU = 4'd2,
        MDU_MULHU  = 4'd3,
        MDU_DIV    = 4'd4,
        MDU_DIVU   = 4'd5,
        MDU_REM    = 4'd6,
        MDU_REMU   = 4'd7,
        MDU_MULW   = 4'd8,
        MDU_DIVW   = 4'd9,
        MDU_DIVUW  = 4'd10,
        MDU_REMW   = 4'd11,
        MDU_REMUW  = 4'd12
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    function automatic logic op_is_legal(input mdu_op_t op);
        return op <= MDU_REMUW;
    endfunction

    function automatic logic op_is_w(input mdu_op_t op);
        return op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
    endfunction

    function automatic logic op_is_mul(input mdu_op_t op);
        return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_MULW};
    endfunction

    function automatic logic op_is_rem(input mdu_op_t op);
        return op inside {MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW};
    endfunction

    function automatic logic op_is_sdiv(input mdu_op_t op);
        return op inside {MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
    endfunction

endpackage

// File: rtl/muldiv_unit_divider.sv
// mdu_divider: radix-2 restoring divider on unsigned magnitudes, one
// iteration per clock. A start pulse loads the operands and iteration
// count; o_done is high during the cycle whose closing edge performs the
// final iteration, so o_quot/o_rem are final from the following cycle on
// and hold until the next start.
//   clk, rst        clock, async active-high reset
//   i_start         load operands and begin
//   i_flush         abandon the running division
//   i_dividend      dividend magnitude (pre-aligned to the top for short ops)
//   i_divisor       divisor magnitude
//   i_n_iter        number of iterations to run
//   o_done          last iteration happens on this cycle's edge
//   o_quot, o_rem   quotient and remainder
module mdu_divider #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic [CNT_W-1:0] i_n_iter,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    // Partial remainder is always below the divisor, so the shifted value
    // needs one extra bit and a negative trial difference shows in its MSB.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_div <= i_divisor;
            r_cnt <= i_n_iter;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (!w_diff[WIDTH]) begin
                r_rem <= w_diff[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_done = (r_cnt == CNT_W'(1));
    assign o_quot = r_quo;
    assign o_rem  = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: integer multiply/divide unit (RV M-extension style).
// Multiplier (single-cycle or shift-add) and control FSM live here; the
// iterative divider is the mdu_divider sub-module.
//   clk, rst             clock, async active-high reset
//   in_valid / in_ready  request handshake (ready only when idle)
//   op, rs1, rs2         opcode (mdu_op_t) and operands
//   flush                abort any in-flight operation
//   out_valid/out_ready  result handshake
//   result               held stable until accepted
//
// state   | meaning
// --------+---------------------------------------------
// ST_IDLE | waiting for a request
// ST_MUL  | multiply in progress
// ST_DIV  | divider iterating
// ST_DONE | result presented, waiting for out_ready
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int FAST_MUL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN + 1);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    mdu_state_t        r_state;
    mdu_state_t        w_state_next;
    mdu_op_t           r_op;
    logic [XLEN-1:0]   r_result;
    logic              r_div_sel;
    logic              r_neg_res;
    logic              r_rem_sel;
    logic              r_w_op;

    mdu_op_t           w_op;
    logic              w_accept;
    logic              w_is_w;
    logic              w_is_mul;
    logic              w_is_rem;
    logic              w_sdiv;
    logic              w_illegal;
    logic              w_special;
    logic [XLEN-1:0]   w_a_ext;
    logic [XLEN-1:0]   w_b_ext;
    logic [XLEN-1:0]   w_a_res;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN-1:0]   w_min;
    logic              w_b_zero;
    logic              w_ovf;
    logic [XLEN-1:0]   w_special_res;
    logic              w_mul_start;
    logic              w_div_start;
    logic [2*XLEN-1:0] w_prod;
    logic              w_mul_done;
    logic [XLEN-1:0]   w_mul_res;
    logic              w_div_done;
    logic [XLEN-1:0]   w_div_quo;
    logic [XLEN-1:0]   w_div_rem;
    logic [XLEN-1:0]   w_div_raw;
    logic [XLEN-1:0]   w_div_signed;
    logic [XLEN-1:0]   w_div_res;

    // Request decode
    assign w_op      = mdu_op_t'(op);
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_is_w    = op_is_w(w_op);
    assign w_is_mul  = op_is_mul(w_op);
    assign w_is_rem  = op_is_rem(w_op);
    assign w_sdiv    = op_is_sdiv(w_op);
    assign w_illegal = !op_is_legal(w_op) || (w_is_w && (XLEN == 32));

    // Divide operands: W ops work on bits [31:0], extended to XLEN so the
    // sign always sits in the MSB.
    assign w_a_ext = w_is_w ? (w_sdiv ? sext32(rs1[31:0]) : XLEN'(rs1[31:0])) : rs1;
    assign w_b_ext = w_is_w ? (w_sdiv ? sext32(rs2[31:0]) : XLEN'(rs2[31:0])) : rs2;
    assign w_a_res = w_is_w ? sext32(rs1[31:0]) : rs1;
    assign w_a_neg = w_sdiv && w_a_ext[XLEN-1];
    assign w_b_neg = w_sdiv && w_b_ext[XLEN-1];
    assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
    assign w_min   = w_is_w ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};

    assign w_b_zero  = (w_b_ext == '0);
    assign w_ovf     = w_sdiv && (w_a_ext == w_min) && (w_b_ext == '1);
    assign w_special = w_illegal || (!w_is_mul && (w_b_zero || w_ovf));

    always_comb begin
        w_special_res = '0;
        if (w_illegal)
            w_special_res = '0;
        else if (w_b_zero)
            w_special_res = w_is_rem ? w_a_res : '1;
        else if (w_ovf)
            w_special_res = w_is_rem ? '0 : w_a_res;
    end

    assign w_mul_start = w_accept && !w_special && w_is_mul;
    assign w_div_start = w_accept && !w_special && !w_is_mul;

    // Multiplier: both variants deliver a 2*XLEN product in w_prod during
    // the cycle that w_mul_done is high.
    if (FAST_MUL != 0) begin : g_fast_mul
        logic [XLEN-1:0]   r_rs1;
        logic [XLEN-1:0]   r_rs2;
        logic              w_sa;
        logic              w_sb;
        logic [2*XLEN-1:0] w_ma;
        logic [2*XLEN-1:0] w_mb;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rs1 <= '0;
                r_rs2 <= '0;
            end else if (w_accept) begin
                r_rs1 <= rs1;
                r_rs2 <= rs2;
            end
        end

        // Sign-extending to 2*XLEN makes one unsigned multiply correct for
        // every signedness combination modulo 2^(2*XLEN).
        assign w_sa       = (r_op == MDU_MULH) || (r_op == MDU_MULHSU);
        assign w_sb       = (r_op == MDU_MULH);
        assign w_ma       = {{XLEN{w_sa & r_rs1[XLEN-1]}}, r_rs1};
        assign w_mb       = {{XLEN{w_sb & r_rs2[XLEN-1]}}, r_rs2};
        assign w_prod     = w_ma * w_mb;
        assign w_mul_done = 1'b1;
    end else begin : g_iter_mul
        logic [2*XLEN-1:0] r_acc;
        logic [2*XLEN-1:0] r_mcand;
        logic [XLEN-1:0]   r_mplier;
        logic              r_mneg;
        logic [CNT_W-1:0]  r_mcnt;
        logic              w_msa;
        logic              w_msb;
        logic [XLEN-1:0]   w_ma_mag;
        logic [XLEN-1:0]   w_mb_mag;
        logic [2*XLEN-1:0] w_acc_next;

        // Shift-add on magnitudes; the sign is restored on the final sum.
        assign w_msa    = ((w_op == MDU_MULH) || (w_op == MDU_MULHSU)) && rs1[XLEN-1];
        assign w_msb    = (w_op == MDU_MULH) && rs2[XLEN-1];
        assign w_ma_mag = w_msa ? -rs1 : rs1;
        assign w_mb_mag = w_msb ? -rs2 : rs2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_acc    <= '0;
                r_mcand  <= '0;
                r_mplier <= '0;
                r_mneg   <= 1'b0;
                r_mcnt   <= '0;
            end else if (flush) begin
                r_mcnt <= '0;
            end else if (w_mul_start) begin
                r_acc    <= '0;
                r_mcand  <= (2*XLEN)'(w_ma_mag);
                r_mplier <= w_mb_mag;
                r_mneg   <= w_msa ^ w_msb;
                r_mcnt   <= w_is_w ? CNT_W'(32) : CNT_W'(XLEN);
            end else if (r_mcnt != '0) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_mcnt   <= r_mcnt - CNT_W'(1);
            end
        end

        assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
        assign w_prod     = r_mneg ? -w_acc_next : w_acc_next;
        assign w_mul_done = (r_mcnt == CNT_W'(1));
    end

    always_comb begin
        w_mul_res = '0;
        case (r_op)
            MDU_MUL:                           w_mul_res = w_prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:   w_mul_res = w_prod[2*XLEN-1:XLEN];
            MDU_MULW:                          w_mul_res = sext32(w_prod[31:0]);
            default:                           w_mul_res = '0;
        endcase
    end

    // Short ops are aligned to the top of the dividend so that 32
    // iterations consume exactly their 32 significant bits.
    mdu_divider #(
        .WIDTH (XLEN),
        .CNT_W (CNT_W)
    ) u_divider (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_flush    (flush),
        .i_dividend (w_is_w ? (w_a_mag << (XLEN - 32)) : w_a_mag),
        .i_divisor  (w_b_mag),
        .i_n_iter   (w_is_w ? CNT_W'(32) : CNT_W'(XLEN)),
        .o_done     (w_div_done),
        .o_quot     (w_div_quo),
        .o_rem      (w_div_rem)
    );

    assign w_div_raw    = r_rem_sel ? w_div_rem : w_div_quo;
    assign w_div_signed = r_neg_res ? -w_div_raw : w_div_raw;
    assign w_div_res    = r_w_op ? sext32(w_div_signed[31:0]) : w_div_signed;

    // Request/result registers. Divider results stay in the divider and
    // are sign-corrected on the way out, selected by r_div_sel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= MDU_MUL;
            r_result  <= '0;
            r_div_sel <= 1'b0;
            r_neg_res <= 1'b0;
            r_rem_sel <= 1'b0;
            r_w_op    <= 1'b0;
        end else if (w_accept) begin
            r_op      <= w_op;
            r_div_sel <= !w_special && !w_is_mul;
            r_neg_res <= w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_rem_sel <= w_is_rem;
            r_w_op    <= w_is_w;
            if (w_special)
                r_result <= w_special_res;
        end else if ((r_state == ST_MUL) && w_mul_done && !flush) begin
            r_result <= w_mul_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_special)
                        w_state_next = ST_DONE;
                    else if (w_is_mul)
                        w_state_next = ST_MUL;
                    else
                        w_state_next = ST_DIV;
                end
            end
            ST_MUL:  if (w_mul_done) w_state_next = ST_DONE;
            ST_DIV:  if (w_div_done) w_state_next = ST_DONE;
            ST_DONE: if (out_ready)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (flush)
            w_state_next = ST_IDLE;
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_div_sel ? w_div_res : r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=64, FAST_MUL=1). The driver pushes
// the expected result and latency on issue; an independent monitor pops
// and compares on the first cycle of each out_valid.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [63:0] rs1 = '0;
    logic [63:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   prev_ov = 1'b0;

    muldiv_unit #(
        .XLEN     (64),
        .FAST_MUL (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Latency = edges from the accepting edge (counted as 1) to out_valid.
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got result %h, required no output", result);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_result"}, result, mon_e.res);
                chk({mon_e.name, "_latency"}, 64'(cyc - mon_e.acc), 64'(mon_e.lat));
            end
        end
        prev_ov = out_valid;
    end

    task automatic issue(input string name, input mdu_op_t o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat,
                         input bit push);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_in_ready: got 0, required 1 within 300 cycles", name);
        end
        op       = o;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        if (push) sb.push_back('{exp, lat, cyc, name});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !in_ready) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending results, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input string name, input mdu_op_t o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat);
        issue(name, o, a, b, exp, lat, 1'b1);
        drain(name);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    result,         64'd0);
        rst = 1'b0;

        run("div_m7_2",    MDU_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run("rem_m7_2",    MDU_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run("divu_by0",    MDU_DIVU,   64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run("remu_by0",    MDU_REMU,   64'd100, 64'd0, 64'd100, 1);
        run("div_ovf",     MDU_DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 1);
        run("rem_ovf",     MDU_REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run("mulhu_max",   MDU_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFE, 2);
        run("mulw_2p32",   MDU_MULW,   64'h0001_0000, 64'h0001_0000, 64'd0, 2);
        run("divw_min_1",  MDU_DIVW,   64'hFFFF_FFFF_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33);
        run("mul_3_m5",    MDU_MUL,    64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 2);
        run("mulh_min_2",  MDU_MULH,   64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run("mulhsu_min",  MDU_MULHSU, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 2);
        run("mulw_neg",    MDU_MULW,   64'hDEAD_0000_0000_0003, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFD, 2);
        run("divu_100_7",  MDU_DIVU,   64'd100, 64'd7, 64'd14, 65);
        run("remu_100_7",  MDU_REMU,   64'd100, 64'd7, 64'd2, 65);
        run("div_7_m2",    MDU_DIV,    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run("rem_7_m2",    MDU_REM,    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
        run("remw_m7_2",   MDU_REMW,   64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run("divuw_big",   MDU_DIVUW,  64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);
        run("divw_ovf",    MDU_DIVW,   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 1);
        run("remuw_by0",   MDU_REMUW,  64'h1234_5678_8000_0005, 64'hABCD_0000_0000_0000,
            64'hFFFF_FFFF_8000_0005, 1);

        // Flush mid-divide, then flush racing a new request.
        issue("flush_divw", MDU_DIVW, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'd0, 0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_in_ready",  64'(in_ready),  64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        op       = MDU_DIVU;
        rs1      = 64'd10;
        rs2      = 64'd2;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_beats_accept", 64'(in_ready), 64'd1);
        repeat (70) @(negedge clk);

        // Consumer stall in DONE.
        out_ready = 1'b0;
        issue("stall_mul", MDU_MUL, 64'd6, 64'd7, 64'd42, 2, 1'b1);
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_result",    result,          64'd42);
            chk("stall_in_ready",  64'(in_ready),   64'd0);
            chk("stall_out_valid", 64'(out_valid),  64'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain("stall_mul");

        // Reset in the middle of a divide.
        issue("rst_div", MDU_DIV, 64'd1000, 64'd3, 64'd0, 0, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_in_ready",  64'(in_ready),  64'd1);
        chk("rst_mid_result",    result,         64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        run("after_rst_mul", MDU_MUL, 64'd12, 64'd12, 64'd144, 2);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter FAST_MUL, default 1; 1 = single-cycle product, 0 = iterative shift-add multiply.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  unit idle and able to accept a request.
REQ-007 SHALL have port op  input  4  mdu_op_t opcode: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW.
REQ-008 SHALL have port rs1  input  XLEN  first operand.
REQ-009 SHALL have port rs2  input  XLEN  second operand.
REQ-010 SHALL have port flush  input  1  abort the in-flight operation.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port result  output  XLEN  operation result, stable while out_valid && !out_ready.

Function
REQ-014 SHALL accept a request on a rising edge with in_valid && in_ready, registering op, rs1 and rs2; in_ready SHALL be high only in IDLE.
REQ-015 SHALL use the FSM states IDLE, MUL, DIV, DONE; IDLE->MUL for multiply ops, IDLE->DIV for divide/remainder ops, IDLE->DONE for divide special cases, MUL/DIV->DONE on completion, DONE->IDLE when out_ready.
REQ-016 SHALL assert out_valid only in DONE and hold result until the out_valid && out_ready edge.
REQ-017 SHALL, with FAST_MUL=1, assert out_valid 2 cycles after acceptance; with FAST_MUL=0, after N+1 cycles.
REQ-018 SHALL run the radix-2 restoring divider for N iterations, one per cycle, asserting out_valid N+1 cycles after acceptance; N = XLEN for full ops and 32 for W ops.
REQ-019 SHALL compute MULH/MULHSU/MULHU as the upper XLEN bits of the 2*XLEN product with signed*signed, signed*unsigned and unsigned*unsigned operands respectively, and MUL as the lower XLEN bits.
REQ-020 SHALL compute signed div/rem on magnitudes; quotient sign = sign(rs1) XOR sign(rs2), remainder sign = sign(rs1).
REQ-021 SHALL, for divisor zero, return quotient all-ones and remainder = dividend, with out_valid 1 cycle after acceptance.
REQ-022 SHALL, for signed overflow (most-negative / -1), return quotient = dividend and remainder 0, with out_valid 1 cycle after acceptance.
REQ-023 SHALL, for W ops, use operand bits [31:0] (sign- or zero-extended per op) and sign-extend bit 31 of the 32-bit result to XLEN.
REQ-024 SHALL treat W ops as illegal when XLEN=32, completing in 1 cycle with result 0.
REQ-025 SHALL, on flush in any state, return to IDLE on the next edge, drop the result and keep out_valid low; flush SHALL override a simultaneous acceptance.
REQ-026 SHALL, when out_ready is low in DONE, stall indefinitely without corrupting result.

Reset
REQ-027 SHALL, while rst is high, force IDLE with in_ready=1, out_valid=0, result=0 and internal counters/registers cleared, independent of clk.
REQ-028 SHALL abandon any in-flight operation on reset, with no output after release.

Structure
REQ-029 SHALL take mdu_op_t and the opcode constants from the shared core package alongside the existing ALU instruction definitions.
REQ-030 SHALL place the iterative divider in sub-module mdu_divider (start/done handshake, N parameterisable); the multiplier and FSM stay in muldiv_unit.

Verification
REQ-031 SHALL cover DIV rs1=-7, rs2=2, XLEN=64 -> result -3 (0xFFFF_FFFF_FFFF_FFFD), out_valid at cycle 65; REM -> -1.
REQ-032 SHALL cover DIVU rs1=100, rs2=0 -> result 0xFFFF_FFFF_FFFF_FFFF after 1 cycle; REMU -> 100.
REQ-033 SHALL cover DIV rs1=0x8000_0000_0000_0000, rs2=-1 -> result 0x8000_0000_0000_0000; REM -> 0; both after 1 cycle.
REQ-034 SHALL cover MULHU rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE; MULW rs1=rs2=0x0001_0000 -> 0 after sign-extension.
REQ-035 SHALL cover DIVW rs1=0xFFFF_FFFF_8000_0000, rs2=1 -> 0xFFFF_FFFF_8000_0000 at cycle 33; flush at cycle 10 -> no out_valid, in_ready high the next cycle.
REQ-036 SHALL cover out_ready held low 5 cycles in DONE -> result stable, in_ready low; rst mid-DIV -> out_valid 0 and in_ready 1 immediately.
